// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and constants for the neuron adder scheduler
package neuron_pkg;
    typedef logic [8:0] vmem_t;
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_e;
    typedef enum logic {OP_ADD, OP_LEAK} op_e;
    localparam vmem_t VMEM_MAX = 9'h1FF;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after ptr, wrapping around
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             valid
);
    always_comb begin
        winner = '0;
        // scan farthest-first so the nearest set request at/after ptr wins last
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req[PW'((int'(ptr) + i) % N_REQ)]) winner = PW'((int'(ptr) + i) % N_REQ);
        valid = |req;
    end
endmodule

// File: rtl/neuron_adder_sched.sv
// neuron_adder_sched: time-shares an external ripple adder between synaptic
// requesters and a periodic leak, accumulating into vmem and firing spikes
module neuron_adder_sched
    import neuron_pkg::*;
#(
    parameter int    N_REQ    = 4,
    parameter int    ADD_WAIT = 3,
    parameter vmem_t LEAK     = 9'd1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   req,
    input  logic [9*N_REQ-1:0] weight,
    input  logic               leak_tick,
    input  logic [8:0]         thresh,
    output logic [N_REQ-1:0]   gnt,
    output logic [8:0]         add_a,
    output logic [8:0]         add_b,
    output logic               add_cin,
    input  logic [8:0]         add_sum,
    input  logic               add_cout,
    output logic [8:0]         vmem,
    output logic               spike,
    output logic               busy
);
    localparam int PW = $clog2(N_REQ);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PW-1:0]   win_q, win_d, rr_ptr_q, rr_ptr_d, arb_win;
    logic            arb_valid, leak_pend_q, leak_pend_d, add_cin_q, add_cin_d;
    logic            spike_q, spike_d, fire;
    vmem_t           vmem_q, vmem_d, add_a_q, add_a_d, add_b_q, add_b_d, r;
    vmem_t           w_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_w
        assign w_arr[g] = weight[9*g +: 9];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req    (req),
        .ptr    (rr_ptr_q),
        .winner (arb_win),
        .valid  (arb_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            win_q       <= '0;
            rr_ptr_q    <= '0;
            leak_pend_q <= 1'b0;
            vmem_q      <= '0;
            spike_q     <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            leak_pend_q <= leak_pend_d;
            vmem_q      <= vmem_d;
            spike_q     <= spike_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (leak_pend_q || arb_valid) begin
                state_d = WAIT;
                cnt_d   = 4'(ADD_WAIT);
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? CAPTURE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // adds saturate on carry-out; leaks subtract via ~LEAK+1, so no carry means borrow
    always_comb begin
        r           = (op_q == OP_ADD) ? (add_cout ? VMEM_MAX : add_sum) : (add_cout ? add_sum : '0);
        fire        = (op_q == OP_ADD) && (r >= thresh);
        op_d        = op_q;
        win_d       = win_q;
        rr_ptr_d    = rr_ptr_q;
        leak_pend_d = leak_pend_q | leak_tick;
        vmem_d      = vmem_q;
        spike_d     = 1'b0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        if (state_q == IDLE && leak_pend_q) begin
            op_d        = OP_LEAK;
            add_a_d     = vmem_q;
            add_b_d     = ~LEAK;
            add_cin_d   = 1'b1;
            leak_pend_d = leak_tick;
        end else if (state_q == IDLE && arb_valid) begin
            op_d      = OP_ADD;
            win_d     = arb_win;
            add_a_d   = vmem_q;
            add_b_d   = w_arr[arb_win];
            add_cin_d = 1'b0;
        end
        if (state_q == CAPTURE) begin
            vmem_d  = fire ? '0 : r;
            spike_d = fire;
            if (op_q == OP_ADD) rr_ptr_d = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        end
    end

    always_comb begin
        gnt  = (state_q == CAPTURE && op_q == OP_ADD) ? (N_REQ'(1) << win_q) : '0;
        busy = (state_q != IDLE);
    end

    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign vmem    = vmem_q;
    assign spike   = spike_q;
endmodule

// File: tb/tb_neuron_adder_sched.sv
// tb_neuron_adder_sched: directed and random checks against an operation-level neuron model
module tb_neuron_adder_sched;
    localparam int N = 4;
    localparam int AW = 3;
    localparam logic [8:0] LK = 9'd1;
    localparam logic [8:0] NLK = ~LK;

    logic CLK = 1'b0, RST = 1'b1, leak_tick = 1'b0, hold = 1'b0;
    logic [N-1:0] req = '0;
    logic [9*N-1:0] weight = '0;
    logic [8:0] thresh = 9'd511;
    logic [N-1:0] gnt;
    logic [8:0] add_a, add_b, add_sum, vmem;
    logic add_cin, add_cout, spike, busy;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {9'b0, add_cin};
    always #5 CLK = ~CLK;

    neuron_adder_sched #(.N_REQ(N), .ADD_WAIT(AW), .LEAK(LK)) dut (
        .CLK(CLK), .RST(RST), .req(req), .weight(weight), .leak_tick(leak_tick),
        .thresh(thresh), .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .vmem(vmem), .spike(spike), .busy(busy)
    );

    int n_cmp = 0, n_err = 0, n_spk = 0, n;
    int m_vmem, m_ptr, m_left, m_win, m_b, m_s;
    bit m_pend, m_busy, m_leak, e_spike;
    logic [N-1:0] e_gnt;
    logic [8:0] prev_vmem = '0;
    int glog[$], vlog[$];

    // operation-level model: one op at a time, leak first, result from plain arithmetic
    always @(posedge CLK) begin
        if (RST) begin
            m_vmem = 0; m_ptr = 0; m_pend = 0; m_busy = 0; m_left = 0;
            m_leak = 0; m_win = 0; m_b = 0; e_gnt = '0; e_spike = 0;
        end else begin
            e_spike = 0;
            e_gnt = '0;
            if (!m_busy) begin
                if (m_pend) begin
                    m_leak = 1; m_pend = leak_tick; m_busy = 1; m_left = AW;
                end else begin
                    m_pend = m_pend | leak_tick;
                    if (req != 0) begin
                        for (int k = 0; k < N; k++)
                            if (req[(m_ptr + k) % N]) begin m_win = (m_ptr + k) % N; break; end
                        m_leak = 0; m_b = int'(weight[9*m_win +: 9]); m_busy = 1; m_left = AW;
                    end
                end
            end else begin
                m_pend = m_pend | leak_tick;
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0 && !m_leak) e_gnt[m_win] = 1'b1;
                end else begin
                    if (m_leak) m_vmem = (m_vmem >= int'(LK)) ? m_vmem - int'(LK) : 0;
                    else begin
                        m_s = m_vmem + m_b;
                        if (m_s > 511) m_s = 511;
                        if (m_s >= int'(thresh)) begin m_vmem = 0; e_spike = 1; end
                        else m_vmem = m_s;
                        m_ptr = (m_win + 1) % N;
                    end
                    m_busy = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        chk("vmem", vmem, m_vmem);
        chk("spike", spike, e_spike);
        chk("gnt", gnt, e_gnt);
        chk("busy", busy, m_busy);
        if (m_busy) begin
            chk("add_a", add_a, m_vmem);
            chk("add_b", add_b, m_leak ? 32'(NLK) : m_b);
            chk("add_cin", add_cin, m_leak);
        end
        if (spike) n_spk++;
        if (gnt != 0) glog.push_back(int'(gnt));
        if (vmem != prev_vmem) vlog.push_back(int'(vmem));
        prev_vmem = vmem;
        if (!hold) req = req & ~gnt;
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin tick(); g++; end while ((m_busy || m_pend || req != 0) && g < 300);
        if (g >= 300) begin n_cmp++; n_err++; $error("FAIL idle_timeout observed=%0d expected<300", g); end
    endtask

    task automatic do_reset();
        RST = 1'b1; tick(); RST = 1'b0;
        glog.delete(); vlog.delete(); n_spk = 0;
    endtask

    task automatic add_op(input int i, input int w);
        weight[9*i +: 9] = 9'(w);
        req[i] = 1'b1;
        wait_idle();
    endtask

    task automatic pulse_leak();
        leak_tick = 1'b1; tick(); leak_tick = 1'b0;
    endtask

    task automatic ticks_to_gnt(output int cnt);
        cnt = 0;
        do begin tick(); cnt++; end while (gnt == 0 && cnt < 40);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(); tick();
        chk("rst_vmem", vmem, 0); chk("rst_spike", spike, 0); chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0); chk("rst_add_a", add_a, 0); chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        RST = 1'b0;
        // single add, latency
        thresh = 9'd300; weight[8:0] = 9'd100; req = 4'b0001;
        ticks_to_gnt(n);
        chk("t1_latency", n, AW + 1); chk("t1_gnt", gnt, 4'b0001);
        wait_idle();
        chk("t1_vmem", vmem, 100); chk("t1_spikes", n_spk, 0); chk("t1_busy", busy, 0);
        // round robin with all requests held
        do_reset();
        thresh = 9'd511; weight = {9'd40, 9'd30, 9'd20, 9'd10}; hold = 1'b1; req = 4'hF;
        n = 0;
        while (glog.size() < 5 && n < 100) begin tick(); n++; end
        hold = 1'b0; req = '0;
        wait_idle();
        chk("t2_ngnt", glog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            int eg[5] = '{1, 2, 4, 8, 1};
            int ev[5] = '{10, 30, 60, 100, 110};
            if (i < glog.size()) chk("t2_order", glog[i], eg[i]);
            if (i < vlog.size()) chk("t2_vmem", vlog[i], ev[i]);
        end
        // saturation then fire at thresh 511
        do_reset();
        add_op(0, 250); add_op(0, 250);
        chk("t3_vmem500", vmem, 500);
        add_op(1, 20);
        chk("t3_spikes", n_spk, 1); chk("t3_vmem", vmem, 0);
        // leak clamps at zero, then 5 -> 4
        do_reset();
        pulse_leak(); wait_idle();
        chk("t4_vmem0", vmem, 0); chk("t4_spikes", n_spk, 0);
        add_op(0, 5); pulse_leak(); wait_idle();
        chk("t4_vmem4", vmem, 4);
        // leak and req[2] arrive together while busy: leak first; leak during WAIT follows the add
        vlog.delete(); glog.delete();
        weight[8:0] = 9'd10; weight[26:18] = 9'd7; req[0] = 1'b1;
        tick(); tick();
        leak_tick = 1'b1; req[2] = 1'b1; tick(); leak_tick = 1'b0;
        wait_idle();
        req[2] = 1'b1; tick(); tick(); pulse_leak(); wait_idle();
        chk("t5_nops", vlog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            int ev[5] = '{14, 13, 20, 27, 26};
            if (i < vlog.size()) chk("t5_vmem", vlog[i], ev[i]);
        end
        chk("t5_ngnt", glog.size(), 3);
        if (glog.size() == 3) begin chk("t5_g0", glog[0], 1); chk("t5_g1", glog[1], 4); chk("t5_g2", glog[2], 4); end
        // reset during WAIT aborts, request is re-served
        weight[17:9] = 9'd33; req = 4'b0010;
        tick(); tick();
        RST = 1'b1; tick();
        chk("t6_gnt", gnt, 0); chk("t6_vmem", vmem, 0); chk("t6_busy", busy, 0);
        chk("t6_add_a", add_a, 0); chk("t6_add_b", add_b, 0); chk("t6_add_cin", add_cin, 0);
        chk("t6_spike", spike, 0);
        RST = 1'b0;
        ticks_to_gnt(n);
        chk("t6_regnt", gnt, 4'b0010);
        wait_idle();
        chk("t6_vmem33", vmem, 33);
        // thresh 0 fires on every add
        do_reset();
        thresh = 9'd0;
        add_op(3, 9); add_op(2, 0);
        chk("t7_spikes", n_spk, 2); chk("t7_vmem", vmem, 0);
        // random traffic against the model
        do_reset();
        thresh = 9'(300 + $urandom_range(0, 211));
        for (int it = 0; it < 600; it++) begin
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    weight[9*i +: 9] = 9'($urandom_range(0, 511));
                    req[i] = 1'b1;
                end
            leak_tick = ($urandom_range(0, 7) == 0);
            if (!m_busy && $urandom_range(0, 31) == 0) thresh = 9'($urandom_range(0, 511));
            tick();
        end
        leak_tick = 1'b0;
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
